// File: rtl/accum_sched_pkg.sv
// Shared types and constants for the accumulation scheduler: FSM state
// encoding, output-map field layout and the read-after-write guard window.
package accum_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    localparam int HAZARD_WIN    = 5;
    localparam int OMAP_W        = 14;
    localparam int OMAP_ADDR_LSB = 0;
    localparam int OMAP_ADDR_W   = 10;
    localparam int OMAP_BRAM_LSB = 10;
    localparam int OMAP_BRAM_W   = 4;
    localparam int COL_W         = 4;

    typedef struct packed {
        logic [OMAP_BRAM_W-1:0] bram;
        logic [OMAP_ADDR_W-1:0] addr;
    } target_t;

    function automatic target_t omap_target(input logic [OMAP_W-1:0] omap);
        target_t t;
        t.bram = omap[OMAP_BRAM_LSB +: OMAP_BRAM_W];
        t.addr = omap[OMAP_ADDR_LSB +: OMAP_ADDR_W];
        return t;
    endfunction

endpackage

// File: rtl/accum_scheduler_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping modulo N)
// wins; returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import accum_sched_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0]     req,
    input  logic [COL_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [COL_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [COL_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (COL_W+1)'(k);
            if (cand >= (COL_W+1)'(N)) begin
                cand = cand - (COL_W+1)'(N);
            end
            if (!grant_any && req[cand[COL_W-1:0]]) begin
                grant[cand[COL_W-1:0]] = 1'b1;
                grant_idx              = cand[COL_W-1:0];
                grant_any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accum_scheduler.sv
// Job scheduler feeding column partial sums into the accumulation datapath.
// Optional read-after-write target guard enabled by defining ACCUM_SCHED_HAZARD_EN.
module accum_scheduler
    import accum_sched_pkg::*;
#(
    parameter int DW        = 16,
    parameter int NUM_COLS  = 16,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           total_cnt,
    output logic                       busy,
    output logic                       done,
    input  logic [NUM_COLS-1:0]        req_valid,
    input  logic [NUM_COLS*DW-1:0]     req_data_flat,
    output logic [NUM_COLS-1:0]        req_ready,
    input  logic [NUM_COLS-1:0]        cmap,
    input  logic [NUM_COLS*OMAP_W-1:0] omap_flat,
    output logic [DW-1:0]              partial_in,
    output logic [COL_W-1:0]           col_id,
    output logic                       partial_valid,
    output logic [CNT_W-1:0]           issued_cnt,
    output sched_state_t               dbg_state
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(1);

    sched_state_t         state;
    logic [CNT_W-1:0]     total_q;
    logic [COL_W-1:0]     ptr;
    logic [COL_W-1:0]     next_ptr;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [NUM_COLS-1:0]  eligible;
    logic [NUM_COLS-1:0]  grant;
    logic [COL_W-1:0]     grant_idx;
    logic                 grant_any;
    logic                 room;
    logic                 hs;

    assign dbg_state = state;

`ifdef ACCUM_SCHED_HAZARD_EN
    // Targets written during the last HAZARD_WIN cycles; a column whose
    // enabled target matches one of them must wait for the write to land.
    target_t                 hist_tgt [HAZARD_WIN];
    logic [HAZARD_WIN-1:0]   hist_vld;
    logic [NUM_COLS-1:0]     hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_vld <= '0;
            for (int w = 0; w < HAZARD_WIN; w++) begin
                hist_tgt[w] <= '0;
            end
        end else begin
            hist_vld    <= {hist_vld[HAZARD_WIN-2:0], hs & cmap[grant_idx]};
            hist_tgt[0] <= omap_target(omap_flat[grant_idx*OMAP_W +: OMAP_W]);
            for (int w = 1; w < HAZARD_WIN; w++) begin
                hist_tgt[w] <= hist_tgt[w-1];
            end
        end
    end

    always_comb begin
        hazard = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            for (int w = 0; w < HAZARD_WIN; w++) begin
                if (cmap[i] && hist_vld[w] &&
                    (omap_target(omap_flat[i*OMAP_W +: OMAP_W]) == hist_tgt[w])) begin
                    hazard[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = req_valid & ~hazard;
`else
    logic unused_omap;
    assign unused_omap = ^omap_flat;
    assign eligible    = req_valid;
`endif

    rr_arbiter #(
        .N (NUM_COLS)
    ) u_arb (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Handshake: column i transfers in a cycle where req_valid[i] & req_ready[i].
    // req_ready is combinational from state and current inputs, at most one bit
    // high, and only while the job still has partials left to consume.
    assign room      = (issued_cnt < total_q);
    assign req_ready = (state == ST_RUN && room && grant_any) ? grant : '0;
    assign hs        = |(req_ready & req_valid);
    assign next_ptr  = (grant_idx == LAST_COL) ? '0 : grant_idx + COL_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            total_q    <= '0;
            issued_cnt <= '0;
            ptr        <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        total_q    <= total_cnt;
                        issued_cnt <= '0;
                        ptr        <= '0;
                        busy       <= 1'b1;
                        if (total_cnt == '0) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        issued_cnt <= issued_cnt + CNT_ONE;
                        ptr        <= next_ptr;
                        if (issued_cnt + CNT_ONE == total_q) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Disabled columns are still consumed and counted, but never marked valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            partial_valid <= 1'b0;
            partial_in    <= '0;
            col_id        <= '0;
        end else if (hs) begin
            partial_valid <= cmap[grant_idx];
            partial_in    <= req_data_flat[grant_idx*DW +: DW];
            col_id        <= grant_idx;
        end else begin
            partial_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_accum_scheduler.sv
// Directed bench for accum_scheduler; expectations adapt when the design is
// built with ACCUM_SCHED_HAZARD_EN.
module tb_accum_scheduler;
    import accum_sched_pkg::*;

    localparam int DW        = 16;
    localparam int NC        = 16;
    localparam int CNT_W     = 16;
    localparam int DRAIN_CYC = 6;
`ifdef ACCUM_SCHED_HAZARD_EN
    localparam int SAME_GAP = HAZARD_WIN + 1;
`else
    localparam int SAME_GAP = 1;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   start;
    logic [CNT_W-1:0]       total_cnt;
    logic                   busy;
    logic                   done;
    logic [NC-1:0]          req_valid;
    logic [NC*DW-1:0]       req_data_flat;
    logic [NC-1:0]          req_ready;
    logic [NC-1:0]          cmap;
    logic [NC*OMAP_W-1:0]   omap_flat;
    logic [DW-1:0]          partial_in;
    logic [COL_W-1:0]       col_id;
    logic                   partial_valid;
    logic [CNT_W-1:0]       issued_cnt;
    sched_state_t           dbg_state;

    logic [DW-1:0]          col_data [NC];
    logic [OMAP_W-1:0]      col_omap [NC];
    int                     tests_run;
    int                     tests_failed;
    int                     grant_col [$];
    int                     grant_cyc [$];
    int                     pv_cyc [$];
    int                     done_cyc;
    int                     done_cnt;
    logic [31:0]            exp_q [$];

    always #5 clk = ~clk;

    accum_scheduler #(
        .DW        (DW),
        .NUM_COLS  (NC),
        .CNT_W     (CNT_W),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .total_cnt     (total_cnt),
        .busy          (busy),
        .done          (done),
        .req_valid     (req_valid),
        .req_data_flat (req_data_flat),
        .req_ready     (req_ready),
        .cmap          (cmap),
        .omap_flat     (omap_flat),
        .partial_in    (partial_in),
        .col_id        (col_id),
        .partial_valid (partial_valid),
        .issued_cnt    (issued_cnt),
        .dbg_state     (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_cols();
        for (int i = 0; i < NC; i++) begin
            req_data_flat[i*DW +: DW]         = col_data[i];
            omap_flat[i*OMAP_W +: OMAP_W]     = col_omap[i];
        end
    endtask

    task automatic default_cols();
        for (int i = 0; i < NC; i++) begin
            col_data[i] = DW'(4096 + i * 17);
            col_omap[i] = {4'(i), 10'(i * 3)};
        end
        apply_cols();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_pv"},    32'(partial_valid), 32'd0);
        check({tag, "_pin"},   32'(partial_in), 32'd0);
        check({tag, "_colid"}, 32'(col_id), 32'd0);
        check({tag, "_issued"},32'(issued_cnt), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // Pulses start, then observes one cycle at a time (cycle 0 = first cycle
    // after the start edge) until the cycle after done, within a fixed budget.
    task automatic run_job(input logic [CNT_W-1:0] total, input int restart_at);
        logic prev_hs;
        int   prev_col;
        logic hs;
        int   col;
        grant_col.delete();
        grant_cyc.delete();
        pv_cyc.delete();
        done_cyc = -1;
        done_cnt = 0;
        prev_hs  = 1'b0;
        prev_col = 0;
        start     = 1'b1;
        total_cnt = total;
        tick();
        start     = 1'b0;
        total_cnt = 16'hBEEF;
        for (int c = 0; c < 200; c++) begin
            start = (c == restart_at);
            hs  = |(req_ready & req_valid);
            col = 0;
            for (int i = 0; i < NC; i++) begin
                if (req_ready[i] && req_valid[i]) col = i;
            end
            if (c == 0) check("busy_first_cycle", 32'(busy), 32'd1);
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (prev_hs) begin
                check("pv_after_hs", 32'(partial_valid), 32'(cmap[prev_col]));
                check("col_id", 32'(col_id), 32'(prev_col));
                check("partial_in", 32'(partial_in), 32'(col_data[prev_col]));
            end else begin
                check("pv_no_hs", 32'(partial_valid), 32'd0);
            end
            if (partial_valid) pv_cyc.push_back(c);
            if (hs) begin
                grant_col.push_back(col);
                grant_cyc.push_back(c);
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                check("busy_at_done", 32'(busy), 32'd0);
            end else if (done_cnt > 0) begin
                break;
            end
            prev_hs  = hs;
            prev_col = col;
            tick();
        end
        start = 1'b0;
        check("job_done_once", 32'(done_cnt), 32'd1);
        check("idle_after_done", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic saw_done;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        total_cnt = '0;
        req_valid = '0;
        cmap      = '1;
        default_cols();
        repeat (2) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single column, 4 partials; a stray start mid-run must be ignored.
        req_valid = 16'h0001;
        run_job(16'd4, 1);
        check("t1_grants", 32'(grant_col.size()), 32'd4);
        for (int k = 0; k < grant_col.size() && k < 4; k++) begin
            check("t1_col", 32'(grant_col[k]), 32'd0);
            check("t1_cyc", 32'(grant_cyc[k]), 32'(k * SAME_GAP));
        end
        check("t1_pv_cnt", 32'(pv_cyc.size()), 32'd4);
        for (int k = 0; k < pv_cyc.size() && k < 4; k++) begin
            check("t1_pv_cyc", 32'(pv_cyc[k]), 32'(k * SAME_GAP + 1));
        end
        check("t1_done_cyc", 32'(done_cyc), 32'(3 * SAME_GAP + 1 + DRAIN_CYC));
        check("t1_issued", 32'(issued_cnt), 32'd4);

        // All columns requesting: strict round-robin from column 0.
        req_valid = 16'hFFFF;
        run_job(16'd20, -1);
        for (int k = 0; k < 20; k++) exp_q.push_back(32'(k % 16));
        check("t2_grants", 32'(grant_col.size()), 32'd20);
        for (int k = 0; k < grant_col.size() && exp_q.size() > 0; k++) begin
            check("t2_order", 32'(grant_col[k]), exp_q.pop_front());
            check("t2_cyc", 32'(grant_cyc[k]), 32'(k));
        end
        exp_q.delete();
        check("t2_pv_cnt", 32'(pv_cyc.size()), 32'd20);
        check("t2_done_cyc", 32'(done_cyc), 32'(19 + 1 + DRAIN_CYC));

        // Columns 0 and 1 share BRAM 2 address 7.
        col_omap[0] = {4'd2, 10'd7};
        col_omap[1] = {4'd2, 10'd7};
        apply_cols();
        req_valid = 16'h0003;
        run_job(16'd2, -1);
        check("t3_grants", 32'(grant_col.size()), 32'd2);
        if (grant_col.size() == 2) begin
            check("t3_first", 32'(grant_col[0]), 32'd0);
            check("t3_second", 32'(grant_col[1]), 32'd1);
            check("t3_gap", 32'(grant_cyc[1] - grant_cyc[0]), 32'(SAME_GAP));
        end
        default_cols();

        // Disabled column: consumed and counted, never marked valid.
        cmap      = 16'hFFFE;
        req_valid = 16'h0001;
        run_job(16'd2, -1);
        check("t4_grants", 32'(grant_col.size()), 32'd2);
        check("t4_pv_never", 32'(pv_cyc.size()), 32'd0);
        check("t4_issued", 32'(issued_cnt), 32'd2);
        cmap = '1;

        // Reset after 3 of 10 issues aborts without done.
        req_valid = 16'hFFFF;
        start     = 1'b1;
        total_cnt = 16'd10;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("t5_issued_pre", 32'(issued_cnt), 32'd3);
        rst_n = 1'b0;
        tick();
        check_all_zero("t5_abort");
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("t5_no_done", 32'(saw_done), 32'd0);
        run_job(16'd3, -1);
        check("t5_grants", 32'(grant_col.size()), 32'd3);
        for (int k = 0; k < grant_col.size() && k < 3; k++) begin
            check("t5_col", 32'(grant_col[k]), 32'(k));
        end
        check("t5_done_cyc", 32'(done_cyc), 32'(2 + 1 + DRAIN_CYC));

        // Empty job goes straight to drain.
        run_job(16'd0, -1);
        check("t6_grants", 32'(grant_col.size()), 32'd0);
        check("t6_pv", 32'(pv_cyc.size()), 32'd0);
        check("t6_done_cyc", 32'(done_cyc), 32'(DRAIN_CYC));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
